mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 17 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter: FSM state
// encoding, port index type, latency counter width and default widths.
package mem_arbiter_pkg;

  localparam int DEF_BITS_DATA = 32;
  localparam int DEF_BITS_ADDR = 16;
  localparam int DEF_MEM_LAT   = 1;

  // Wide enough for the largest legal memory latency (15).
  localparam int CNT_W  = 4;
  localparam int PORT_W = 1;

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin winner selection. This block is purely
// combinational. On a tie it grants the port that did not win last time.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output port_idx_t  grant
);

  // A lone requester wins outright. The pointer only breaks ties.
  always_comb begin
    if (req == 2'b11) grant = ~last;
    else              grant = req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter. It serialises CPU (port 0) and
// I/O/DMA (port 1) accesses onto one fixed-latency memory, with all outputs registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BITS_DATA = DEF_BITS_DATA,
  parameter int BITS_ADDR = DEF_BITS_ADDR,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 wr0,
  input  logic                 wr1,
  input  logic [BITS_ADDR-1:0] addr0,
  input  logic [BITS_ADDR-1:0] addr1,
  input  logic [BITS_DATA-1:0] wdata0,
  input  logic [BITS_DATA-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [BITS_DATA-1:0] rdata0,
  output logic [BITS_DATA-1:0] rdata1,
  output logic [BITS_ADDR-1:0] MAR,
  output logic [BITS_DATA-1:0] MBR_W,
  output logic                 write,
  input  logic [BITS_DATA-1:0] MBR_R
);

  state_t     state, state_d;
  logic [CNT_W-1:0] cnt;
  port_idx_t  winner;
  port_idx_t  last_grant;
  port_idx_t  grant;
  logic       grant_load;
  logic       finish;

  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .last  (last_grant),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    state_d    = state;
    grant_load = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = ACCESS;
          grant_load = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == CNT_W'(1)) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments only. This way every
  // right-hand side reads the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      MAR        <= '0;
      MBR_W      <= '0;
      write      <= 1'b0;
      cnt        <= '0;
      winner     <= '0;
      // Recording port 1 as the last winner gives port 0 the first tie.
      last_grant <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant_load) begin
        MAR        <= grant ? addr1  : addr0;
        MBR_W      <= grant ? wdata1 : wdata0;
        write      <= grant ? wr1    : wr0;
        cnt        <= CNT_W'(MEM_LAT);
        winner     <= grant;
        last_grant <= grant;
      end else if (state == ACCESS) begin
        cnt <= cnt - CNT_W'(1);
      end
      // The write register still marks the transaction type on the finishing edge.
      if (finish) begin
        write <= 1'b0;
        if (winner == 1'b0) begin
          ack0 <= 1'b1;
          if (!write) rdata0 <= MBR_R;
        end else begin
          ack1 <= 1'b1;
          if (!write) rdata1 <= MBR_R;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It runs directed scenarios and then
// randomised two-port traffic, checked against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, wr0, wr1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [15:0] MAR;
  logic [31:0] MBR_W, MBR_R;
  logic        write;

  logic        l3_req0;
  logic [15:0] l3_addr0;
  logic        l3_ack0, l3_ack1, l3_write;
  logic [31:0] l3_rdata0, l3_rdata1, l3_mbr_w, l3_mbr_r;
  logic [15:0] l3_mar;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int          checks = 0;
  int          failures = 0;
  bit          last_model;
  bit          pend0, pend1, w;
  logic [31:0] exp_rd0, exp_rd1;
  logic        wr_w;
  logic [15:0] addr_w;
  logic [31:0] data_w;
  int          n;

  always #5 clk = ~clk;

  mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .MAR(MAR), .MBR_W(MBR_W), .write(write), .MBR_R(MBR_R)
  );

  mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .MEM_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .req0(l3_req0), .req1(1'b0), .wr0(1'b0), .wr1(1'b0),
    .addr0(l3_addr0), .addr1(16'h0000), .wdata0(32'h0), .wdata1(32'h0),
    .ack0(l3_ack0), .ack1(l3_ack1), .rdata0(l3_rdata0), .rdata1(l3_rdata1),
    .MAR(l3_mar), .MBR_W(l3_mbr_w), .write(l3_write), .MBR_R(l3_mbr_r)
  );

  assign MBR_R    = mem[MAR[7:0]];
  assign l3_mbr_r = (l3_mar == 16'h0020) ? 32'hCAFE_F00D : 32'h0;

  always @(posedge clk) begin
    if (write) mem[MAR[7:0]] <= MBR_W;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_req(input bit p);
    if (p) begin
      req1   = 1'b1;
      wr1    = 1'($urandom_range(1, 0));
      addr1  = 16'(32'h40 + $urandom_range(15, 0));
      wdata1 = $urandom;
      pend1  = 1'b1;
    end else begin
      req0   = 1'b1;
      wr0    = 1'($urandom_range(1, 0));
      addr0  = 16'(32'h40 + $urandom_range(15, 0));
      wdata0 = $urandom;
      pend0  = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0;
    {req0, req1, wr0, wr1} = 4'b0;
    {addr0, addr1} = '0;
    {wdata0, wdata1} = '0;
    l3_req0 = 1'b0;
    l3_addr0 = 16'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEAD_BEEF;
    ref_mem[8'h10] = 32'hDEAD_BEEF;

    // Reset values
    @(negedge clk);
    step();
    check("rst_ack", 32'({ack1, ack0}), 32'h0);
    check("rst_write", 32'(write), 32'h0);
    check("rst_mar", 32'(MAR), 32'h0);
    check("rst_mbr_w", MBR_W, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    reset = 1'b1;
    last_model = 1'b1;

    // Port 0 read of 0x0010
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0010;
    step();
    check("rd_mar", 32'(MAR), 32'h10);
    check("rd_ack_early", 32'({ack1, ack0}), 32'h0);
    step();
    check("rd_ack", 32'({ack1, ack0}), 32'h1);
    check("rd_rdata0", rdata0, 32'hDEAD_BEEF);
    req0 = 1'b0;
    step();
    check("rd_ack_one_cycle", 32'({ack1, ack0}), 32'h0);

    // Port 1 write to 0x00FF, then read back through port 0
    req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h00FF; wdata1 = 32'h1234_5678;
    step();
    check("wr_write", 32'(write), 32'h1);
    check("wr_mar", 32'(MAR), 32'hFF);
    check("wr_mbr_w", MBR_W, 32'h1234_5678);
    step();
    check("wr_ack", 32'({ack1, ack0}), 32'h2);
    check("wr_write_low", 32'(write), 32'h0);
    check("wr_rdata1_kept", rdata1, 32'h0);
    req1 = 1'b0;
    ref_mem[8'hFF] = 32'h1234_5678;
    step();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h00FF;
    step();
    step();
    check("rb_ack", 32'({ack1, ack0}), 32'h1);
    check("rb_rdata0", rdata0, 32'h1234_5678);
    req0 = 1'b0;
    step();

    // req0 dropped mid-access while req1 is pending
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0010;
    step();
    req0 = 1'b0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0020;
    step();
    check("drop_ack0", 32'({ack1, ack0}), 32'h1);
    check("drop_rdata0", rdata0, 32'hDEAD_BEEF);
    step();
    step();
    check("drop_no_ack", 32'({ack1, ack0}), 32'h0);
    step();
    check("drop_ack1", 32'({ack1, ack0}), 32'h2);
    check("drop_rdata1", rdata1, ref_mem[8'h20]);
    req1 = 1'b0;
    step();

    // Both ports held continuously right after reset: 0,1,0,1,0 every 3 cycles
    reset = 1'b0;
    step();
    reset = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0020;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("rr_cycle%0d", i), 32'({ack1, ack0}),
            (i % 3 == 2) ? (((i / 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check("rr_tail_ack1", 32'({ack1, ack0}), 32'h2);
    step();

    // Reset asserted during a write access aborts it
    req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0030; wdata1 = 32'hA5A5_5A5A;
    step();
    check("abort_write_high", 32'(write), 32'h1);
    reset = 1'b0;
    step();
    check("abort_write_low", 32'(write), 32'h0);
    check("abort_no_ack", 32'({ack1, ack0}), 32'h0);
    check("abort_rdata0", rdata0, 32'h0);
    check("abort_rdata1", rdata1, 32'h0);
    ref_mem[8'h30] = 32'hA5A5_5A5A;
    reset = 1'b1;
    req1 = 1'b0; wr1 = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0030;
    step();
    step();
    check("post_abort_ack0", 32'({ack1, ack0}), 32'h1);
    check("post_abort_rdata0", rdata0, 32'hA5A5_5A5A);
    req0 = 1'b0;
    step();

    // Random two-port traffic against the transaction-level model
    last_model = 1'b0;
    exp_rd0 = 32'hA5A5_5A5A;
    exp_rd1 = 32'h0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!pend0 && ($urandom_range(1, 0) == 1)) new_req(1'b0);
      if (!pend1 && ($urandom_range(1, 0) == 1)) new_req(1'b1);
      if (!pend0 && !pend1) new_req(1'($urandom_range(1, 0)));
      w = (pend0 && pend1) ? ~last_model : pend1;
      last_model = w;
      wr_w   = w ? wr1 : wr0;
      addr_w = w ? addr1 : addr0;
      data_w = w ? wdata1 : wdata0;
      if (wr_w) ref_mem[addr_w[7:0]] = data_w;
      else if (w) exp_rd1 = ref_mem[addr_w[7:0]];
      else exp_rd0 = ref_mem[addr_w[7:0]];
      n = 0;
      do begin
        step();
        n++;
        if (n == 1) begin
          check("rnd_mar", 32'(MAR), 32'(addr_w));
          check("rnd_write", 32'(write), 32'(wr_w));
        end
      end while (!(ack0 || ack1) && n < 8);
      check("rnd_latency", 32'(n), 32'd2);
      check("rnd_ack_port", 32'({ack1, ack0}), w ? 32'h2 : 32'h1);
      check("rnd_rdata0", rdata0, exp_rd0);
      check("rnd_rdata1", rdata1, exp_rd1);
      if (w) begin req1 = 1'b0; pend1 = 1'b0; end
      else   begin req0 = 1'b0; pend0 = 1'b0; end
      step();
      check("rnd_ack_clear", 32'({ack1, ack0}), 32'h0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    step();

    // Latency 3 instance: port 0 read of 0x0020
    l3_req0 = 1'b1;
    l3_addr0 = 16'h0020;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("l3_ack1_c%0d", i), 32'(l3_ack1), 32'h0);
      if (i < 4) begin
        check($sformatf("l3_mar_c%0d", i), 32'(l3_mar), 32'h20);
        check($sformatf("l3_ack0_c%0d", i), 32'(l3_ack0), 32'h0);
      end
    end
    check("l3_ack0", 32'(l3_ack0), 32'h1);
    check("l3_rdata0", l3_rdata0, 32'hCAFE_F00D);
    check("l3_write", 32'(l3_write), 32'h0);
    check("l3_mbr_w", l3_mbr_w, 32'h0);
    check("l3_rdata1", l3_rdata1, 32'h0);
    l3_req0 = 1'b0;
    step();
    check("l3_ack0_clear", 32'(l3_ack0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
